// File: rtl/taxi_axil_if.sv
// AXI-lite interface bundle with separate write and read slave/master modports.
interface taxi_axil_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned STRB_W = DATA_W / 8
) ();
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
  modport rd_slv (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
  modport wr_mst (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport rd_mst (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cndm_queue_mgr.sv
// Multi-queue descriptor-fetch manager: per-queue AXI-lite registers and a round-robin
// request issuer. Define CNDM_QUEUE_MGR_STATS_EN for per-queue request counters at +0x10.
module cndm_queue_mgr #(
  parameter int unsigned NUM_Q          = 4,
  parameter int unsigned QN_W           = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
  parameter int unsigned DESC_SIZE_LOG2 = 4,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned AXIL_ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  taxi_axil_if.wr_slv       s_axil_wr,
  taxi_axil_if.rd_slv       s_axil_rd,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [QN_W-1:0]   req_qn,
  output logic [ADDR_W-1:0] req_addr,
  output logic [15:0]       req_idx,
  output logic [NUM_Q-1:0]  q_pending
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;
  state_e state_q, state_d;

  logic [NUM_Q-1:0] en_q;
  logic [3:0]       size_q [NUM_Q];
  logic [15:0]      prod_q [NUM_Q];
  logic [15:0]      cons_q [NUM_Q];
  logic [63:0]      base_q [NUM_Q];
  logic [NUM_Q-1:0] pend_q;
  logic             hs_q;
  logic [QN_W-1:0]  ptr_q, qn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]      idx_q;

  logic             aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
  logic [31:0]      rdata_q;

  logic                   wr_fire, wr_hit, rd_fire, rd_hit;
  logic [AXIL_ADDR_W-6:0] wr_qf, rd_qf;
  logic [QN_W-1:0]        wr_q, rd_q;
  logic [2:0]             wr_word, rd_word;
  logic [31:0]            wdata, rd_data;

  logic [NUM_Q-1:0] avail;
  logic             gnt_found, grant, hs;
  logic [QN_W-1:0]  gnt_qn, cand;
  logic [15:0]      gnt_cons, gnt_mask;
  logic [63:0]      gnt_off;
  logic [ADDR_W-1:0] gnt_addr;

  logic unused_bits;
  assign unused_bits = ^{s_axil_wr.awaddr[1:0], s_axil_wr.wstrb, s_axil_rd.araddr[1:0]};

  // Address decode
  assign wr_fire = aw_rdy_q && s_axil_wr.awvalid && s_axil_wr.wvalid;
  assign wr_qf   = s_axil_wr.awaddr[AXIL_ADDR_W-1:5];
  assign wr_word = s_axil_wr.awaddr[4:2];
  assign wr_q    = wr_qf[QN_W-1:0];
  assign wr_hit  = wr_fire && (32'(wr_qf) < NUM_Q);
  assign wdata   = s_axil_wr.wdata;

  assign rd_fire = ar_rdy_q && s_axil_rd.arvalid;
  assign rd_qf   = s_axil_rd.araddr[AXIL_ADDR_W-1:5];
  assign rd_word = s_axil_rd.araddr[4:2];
  assign rd_q    = rd_qf[QN_W-1:0];
  assign rd_hit  = 32'(rd_qf) < NUM_Q;

  assign s_axil_wr.awready = aw_rdy_q;
  assign s_axil_wr.wready  = aw_rdy_q;
  assign s_axil_wr.bresp   = 2'b00;
  assign s_axil_wr.bvalid  = bvalid_q;
  assign s_axil_rd.arready = ar_rdy_q;
  assign s_axil_rd.rdata   = rdata_q;
  assign s_axil_rd.rresp   = 2'b00;
  assign s_axil_rd.rvalid  = rvalid_q;

`ifdef CNDM_QUEUE_MGR_STATS_EN
  logic [31:0] stats_q [NUM_Q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < NUM_Q; n++) stats_q[n] <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_Q; n++) begin
        if (hs && qn_q == QN_W'(n)) stats_q[n] <= stats_q[n] + 32'd1;
        // A clear in the same cycle as a handshake wins
        if (wr_hit && wr_q == QN_W'(n) && wr_word == 3'd4) stats_q[n] <= '0;
      end
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (rd_word)
        3'd0:    rd_data = {12'd0, size_q[rd_q], 15'd0, en_q[rd_q]};
        3'd1:    rd_data = {cons_q[rd_q], prod_q[rd_q]};
        3'd2:    rd_data = base_q[rd_q][31:0];
        3'd3:    rd_data = base_q[rd_q][63:32];
`ifdef CNDM_QUEUE_MGR_STATS_EN
        3'd4:    rd_data = stats_q[rd_q];
`endif
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      aw_rdy_q <= s_axil_wr.awvalid && s_axil_wr.wvalid && !bvalid_q && !aw_rdy_q;
      if (bvalid_q && s_axil_wr.bready) bvalid_q <= 1'b0;
      if (wr_fire) bvalid_q <= 1'b1;
      ar_rdy_q <= s_axil_rd.arvalid && !rvalid_q && !ar_rdy_q;
      if (rvalid_q && s_axil_rd.rready) rvalid_q <= 1'b0;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end
    end
  end

  // Per-queue control registers; a prod write to a disabled queue also resets cons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int unsigned n = 0; n < NUM_Q; n++) begin
        size_q[n] <= '0;
        prod_q[n] <= '0;
        cons_q[n] <= '0;
        base_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_Q; n++) begin
        if (hs && qn_q == QN_W'(n)) cons_q[n] <= cons_q[n] + 16'd1;
        if (wr_hit && wr_q == QN_W'(n)) begin
          case (wr_word)
            3'd0: begin
              en_q[n]   <= wdata[0];
              size_q[n] <= wdata[19:16];
            end
            3'd1: begin
              prod_q[n] <= wdata[15:0];
              if (!en_q[n]) cons_q[n] <= wdata[15:0];
            end
            3'd2:    base_q[n][31:0]  <= wdata;
            3'd3:    base_q[n][63:32] <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Round-robin search from ptr+1; the queue handshaken last cycle still looks pending
  // because pend_q lags cons by one cycle, so it is masked out.
  always_comb begin
    avail = pend_q;
    if (hs_q) avail[qn_q] = 1'b0;
    gnt_found = 1'b0;
    gnt_qn    = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_Q; i++) begin
      cand = QN_W'((32'(ptr_q) + i) % NUM_Q);
      if (!gnt_found && avail[cand]) begin
        gnt_found = 1'b1;
        gnt_qn    = cand;
      end
    end
    gnt_cons = cons_q[gnt_qn];
    gnt_mask = 16'((17'd1 << size_q[gnt_qn]) - 17'd1);
    gnt_off  = 64'(gnt_cons & gnt_mask) << DESC_SIZE_LOG2;
    gnt_addr = ADDR_W'(base_q[gnt_qn] + gnt_off);

    state_d = state_q;
    grant   = 1'b0;
    hs      = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt_found) begin
          state_d = StReq;
          grant   = 1'b1;
        end
      end
      StReq: begin
        if (req_ready) begin
          state_d = StIdle;
          hs      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= QN_W'(NUM_Q - 1);
      qn_q    <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      hs_q    <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs;
      if (grant) begin
        ptr_q  <= gnt_qn;
        qn_q   <= gnt_qn;
        idx_q  <= gnt_cons;
        addr_q <= gnt_addr;
      end
      for (int unsigned n = 0; n < NUM_Q; n++) begin
        pend_q[n] <= en_q[n] && (prod_q[n] != cons_q[n]);
      end
    end
  end

  assign req_valid = (state_q == StReq);
  assign req_qn    = qn_q;
  assign req_idx   = idx_q;
  assign req_addr  = addr_q;
  assign q_pending = pend_q;

endmodule

// File: tb/tb_cndm_queue_mgr.sv
// Directed self-checking bench for cndm_queue_mgr (default NUM_Q=4, 64-bit addresses).
module tb_cndm_queue_mgr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [1:0]  req_qn;
  logic [63:0] req_addr;
  logic [15:0] req_idx;
  logic [3:0]  q_pending;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(16)) axil ();

  cndm_queue_mgr #(
    .NUM_Q(4), .QN_W(2), .DESC_SIZE_LOG2(4), .ADDR_W(64), .AXIL_ADDR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axil_wr(axil), .s_axil_rd(axil),
    .req_valid(req_valid), .req_ready(req_ready), .req_qn(req_qn),
    .req_addr(req_addr), .req_idx(req_idx), .q_pending(q_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  logic [1:0]  log_qn   [256];
  logic [15:0] log_idx  [256];
  logic [63:0] log_addr [256];

  // Inputs only change just after posedge, so a negedge sample predicts the handshake
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      if (hs_cnt < 256) begin
        log_qn[hs_cnt]   = req_qn;
        log_idx[hs_cnt]  = req_idx;
        log_addr[hs_cnt] = req_addr;
      end
      hs_cnt = hs_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 req_ready = v;
  endtask

  task automatic axil_write(input logic [15:0] addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    axil.awaddr = addr; axil.awvalid = 1'b1;
    axil.wdata = data; axil.wvalid = 1'b1; axil.wstrb = 4'hf; axil.bready = 1'b1;
    n = 0;
    while (!axil.awready && n < 20) begin @(negedge clk); n++; end
    check_eq("awready", axil.awready & axil.wready, 1);
    @(posedge clk);
    #1 axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    n = 0;
    while (!axil.bvalid && n < 20) begin @(negedge clk); n++; end
    check_eq("bvalid", {axil.bvalid, axil.bresp}, 3'b100);
    @(posedge clk);
    #1 axil.bready = 1'b0;
  endtask

  task automatic axil_read(input logic [15:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    axil.araddr = addr; axil.arvalid = 1'b1; axil.rready = 1'b1;
    n = 0;
    while (!axil.arready && n < 20) begin @(negedge clk); n++; end
    check_eq("arready", axil.arready, 1);
    @(posedge clk);
    #1 axil.arvalid = 1'b0;
    n = 0;
    while (!axil.rvalid && n < 20) begin @(negedge clk); n++; end
    check_eq("rvalid", {axil.rvalid, axil.rresp}, 3'b100);
    data = axil.rdata;
    @(posedge clk);
    #1 axil.rready = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 200) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    check_eq("hs_count", hs_cnt, target);
  endtask

  logic [1:0]  exp_ord [6];
  logic [15:0] exp_idx [3];
  logic [63:0] exp_adr [3];
  int b;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
    axil.wvalid = 1'b0; axil.bready = 1'b0; axil.araddr = '0; axil.arvalid = 1'b0;
    axil.rready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", {req_valid, req_qn, req_idx}, 0);
    check_eq("rst_addr", req_addr, 0);
    check_eq("rst_pend", q_pending, 0);
    check_eq("rst_axil", {axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid}, 0);
    check_eq("rst_rdata", axil.rdata, 0);
    rst_n = 1'b1;

    // Q1 linear fetch
    set_ready(1'b1);
    b = hs_cnt;
    axil_write(16'h0028, 32'h0000_1000);
    axil_write(16'h002c, 32'h0000_0001);
    axil_write(16'h0020, 32'h0004_0001);
    axil_write(16'h0024, 32'h0000_0003);
    wait_hs(b + 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("q1_qn", log_qn[b+i], 1);
      check_eq("q1_idx", log_idx[b+i], 64'(i));
      check_eq("q1_addr", log_addr[b+i], 64'h1_0000_1000 + 64'(i * 16));
    end
    read_chk("q1_prodcons", 16'h0024, 32'h0003_0003);
    read_chk("q1_ctrl", 16'h0020, 32'h0004_0001);
    check_eq("q1_pend", q_pending, 0);

    // Round-robin across Q0, Q2, Q3
    set_ready(1'b0);
    b = hs_cnt;
    axil_write(16'h0000, 32'h0004_0001);
    axil_write(16'h0040, 32'h0004_0001);
    axil_write(16'h0060, 32'h0004_0001);
    axil_write(16'h0004, 32'h0000_0002);
    axil_write(16'h0044, 32'h0000_0002);
    axil_write(16'h0064, 32'h0000_0002);
    check_eq("rr_pend", q_pending, 4'b1101);
    set_ready(1'b1);
    wait_hs(b + 6);
    exp_ord = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    for (int i = 0; i < 6; i++) check_eq("rr_order", log_qn[b+i], exp_ord[i]);
    check_eq("rr_idx", log_idx[b+3], 1);
    read_chk("rr_q3", 16'h0064, 32'h0002_0002);

    // Reset asserted while a request is outstanding
    set_ready(1'b0);
    axil_write(16'h0004, 32'h0000_0003);
    repeat (4) @(negedge clk);
    check_eq("mid_req_vld", req_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("mid_rst_vld", req_valid, 0);
    check_eq("mid_rst_pend", q_pending, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_chk("mid_ctrl0", 16'h0000, 32'h0);
    read_chk("mid_pc0", 16'h0004, 32'h0);
    read_chk("mid_base1", 16'h0028, 32'h0);
    read_chk("mid_baseh1", 16'h002c, 32'h0);

    // Q0 16-bit index wrap with size=2
    b = hs_cnt;
    axil_write(16'h0000, 32'h0002_0000);
    axil_write(16'h0004, 32'h0000_fffe);
    axil_write(16'h0008, 32'h0000_8000);
    axil_write(16'h0000, 32'h0002_0001);
    set_ready(1'b1);
    axil_write(16'h0004, 32'h0000_0001);
    wait_hs(b + 3);
    exp_idx = '{16'hfffe, 16'hffff, 16'h0000};
    exp_adr = '{64'h8020, 64'h8030, 64'h8000};
    for (int i = 0; i < 3; i++) begin
      check_eq("wrap_qn", log_qn[b+i], 0);
      check_eq("wrap_idx", log_idx[b+i], exp_idx[i]);
      check_eq("wrap_addr", log_addr[b+i], exp_adr[i]);
    end
    read_chk("wrap_pc", 16'h0004, 32'h0001_0001);

    // Q3 stalled by req_ready, disabled during the stall
    set_ready(1'b0);
    b = hs_cnt;
    axil_write(16'h0068, 32'h0000_4000);
    axil_write(16'h0060, 32'h0004_0001);
    axil_write(16'h0064, 32'h0000_0002);
    begin
      int n;
      n = 0;
      while (!req_valid && n < 20) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_vld", req_valid, 1);
      check_eq("stall_addr", req_addr, 64'h4000);
    end
    axil_write(16'h0060, 32'h0004_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_fields", {req_valid, req_qn, req_idx}, {1'b1, 2'd3, 16'd0});
      check_eq("stall_addr2", req_addr, 64'h4000);
    end
    set_ready(1'b1);
    wait_hs(b + 1);
    check_eq("stall_log", {log_qn[b], log_idx[b]}, {2'd3, 16'd0});
    check_eq("stall_log_addr", log_addr[b], 64'h4000);
    read_chk("stall_pc", 16'h0064, 32'h0001_0002);
    check_eq("stall_pend", q_pending, 0);

    // Q2 five handshakes, stats word and out-of-range queue
    b = hs_cnt;
    axil_write(16'h0040, 32'h0004_0001);
    axil_write(16'h0044, 32'h0000_0005);
    wait_hs(b + 5);
    for (int i = 0; i < 5; i++) check_eq("st_qn", log_qn[b+i], 2);
    read_chk("st_pc", 16'h0044, 32'h0005_0005);
`ifdef CNDM_QUEUE_MGR_STATS_EN
    read_chk("stats5", 16'h0050, 32'd5);
    axil_write(16'h0050, 32'h0000_0000);
    read_chk("stats_clr", 16'h0050, 32'd0);
`else
    read_chk("stats_off", 16'h0050, 32'd0);
    axil_write(16'h0050, 32'h0000_0007);
    read_chk("stats_off_wr", 16'h0050, 32'd0);
`endif
    axil_write(16'h0088, 32'h1234_5678);
    read_chk("oob_base", 16'h0088, 32'd0);
    read_chk("oob_ctrl", 16'h0080, 32'd0);
    read_chk("word5", 16'h0054, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cndm_queue_mgr.md
Name: cndm_queue_mgr

Overview:
- Parametrised multi-queue manager for Corundum-micro ports; generalises the fixed single TX/RX queue-pair control into NUM_Q descriptor queues.
- Holds per-queue control registers behind AXI-lite.
- Round-robin selects queues with outstanding work and issues one descriptor-fetch request per handshake, advancing the consumer pointer.
- Sits between the port register space and the descriptor-read engine.

Parameters:
- NUM_Q, 4, number of queues (1..256).
- QN_W, $clog2(NUM_Q) min 1, queue-number width.
- DESC_SIZE_LOG2, 4, log2 descriptor size in bytes (16 B).
- ADDR_W, 64, host address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axil_wr  taxi_axil_if.wr_slv  32-bit data  register write channel.
- s_axil_rd  taxi_axil_if.rd_slv  32-bit data  register read channel.
- req_valid  out  1  descriptor-fetch request valid.
- req_ready  in  1  request accepted.
- req_qn  out  QN_W  queue number of the request.
- req_addr  out  ADDR_W  descriptor host address.
- req_idx  out  16  consumer index being fetched (unmasked).
- q_pending  out  NUM_Q  per-queue enabled && prod!=cons.

Behaviour:
- Reset: asynchronous on rst_n low; all registers and outputs are 0.
  - Outputs include req_valid, req_qn, req_addr, req_idx, q_pending, AXI-lite ready/valid and rdata.
  - Round-robin pointer resets to NUM_Q-1, so queue 0 is first.
- Register map: queue n at byte offset n*0x20; word = addr[4:2]; n = addr[AXIL_ADDR_W-1:5].
  - +0x00 ctrl: bit0 en, [19:16] size (log2 entries).
  - +0x04: [15:0] prod RW, [31:16] cons RO.
  - +0x08: base[31:0].
  - +0x0c: base[63:32].
  - +0x10: stats (optional feature).
  - Other words, or n>=NUM_Q: writes ignored, reads 0.
  - wstrb is ignored (full-word writes).
- AXI-lite write: accepted when awvalid && wvalid && !bvalid. awready and wready pulse for 1 cycle, the register updates on that edge, and bvalid asserts the next cycle and holds until bready.
- AXI-lite read: accepted when arvalid && !rvalid. arready pulses for 1 cycle; rdata/rvalid are valid the next cycle and hold until rready. bresp/rresp are always 0.
- Prod write: if the queue is enabled, sets prod only. If disabled, sets both prod and cons to wdata[15:0] (queue reset).
- Pending: q_pending[n] = en[n] && prod[n]!=cons[n]. Registered, so it reflects register state with 1-cycle latency.
- Arbiter states:
  - IDLE: when req_valid=0 and some q_pending bit is set (excluding the queue just granted in the previous cycle), grant the first pending queue searching upward from ptr+1 with wrap.
    - Register req_qn, req_idx=cons, req_addr = base + ((cons & ((1<<size)-1)) << DESC_SIZE_LOG2), computed mod 2^ADDR_W.
    - Assert req_valid; ptr <= granted queue.
  - REQ: req_valid and payload are held stable until req_ready.
    - On handshake: cons[qn] <= cons[qn]+1 (mod 2^16), req_valid <= 0.
    - Return to IDLE.
- Throughput: at most 1 request per 2 cycles.
- Latency: a queue becoming pending to req_valid is 2 cycles (pending register + grant).
- Disable while in REQ: the request still completes and cons advances. No new grants for that queue.
- Simultaneous handshake and prod write to the same queue: prod takes the write; cons increments.
  - Exception: if the queue is disabled, the register write wins for cons.
- Size > 15 cannot occur (4-bit field). Size 0 means mask 0, so the address equals base.
- Wrap-around: prod and cons compare as full 16-bit values. Software guarantees prod-cons <= 2^size.

Optional Feature:
- CNDM_QUEUE_MGR_STATS_EN defined: per-queue 32-bit counter at +0x10.
  - Increments on each request handshake for that queue, wrapping at 2^32.
  - Any write to +0x10 clears it. Handshake on the same cycle as a clear yields 0.
- Not defined: no counters; +0x10 reads 0 and writes are ignored.

Test Plan:
- Reset mid-request (req_valid=1, rst_n pulsed low asynchronously) -> req_valid=0 immediately, all registers read 0 after release.
- Q1: base=0x1_0000_1000, size=4, en=1, prod=3, req_ready=1 -> exactly 3 requests, qn=1, idx 0,1,2, addr 0x1_0000_1000/1010/1020; then cons=3 and q_pending[1]=0.
- Q0, Q2, Q3 all enabled with prod=2, req_ready=1 -> grant order 0,2,3,0,2,3, each qn twice.
- Q0: size=2, cons=0xFFFE (via disabled prod write), en=1, prod=0x0001 -> 3 requests, idx FFFE,FFFF,0000, addr offsets 0x20,0x30,0x00; cons=0x0001.
- req_ready held 0 for 10 cycles, ctrl en=0 written meanwhile -> req fields stable, request completes when ready=1, no further Q requests.
- STATS_EN: 5 handshakes on Q2 -> +0x10 reads 5; write clears -> reads 0; read of queue index NUM_Q -> 0.
